// File: rtl/usb_fx2_slave_writer_pkg.sv
// Shared constants and state encoding for the FX2 slave-FIFO writer.
//   FX2_END_MARKER : frame terminator word produced by the USB packing stage
//   FX2_EPx_ADDR   : FIFOADR codes for the four FX2 endpoints
//   state_t        : writer FSM states
package usb_fx2_slave_writer_pkg;

   localparam int          WORD_W         = 32;
   localparam int          FD_W           = 16;
   localparam logic [31:0] FX2_END_MARKER = 32'hFAFAE0E0;

   localparam logic [1:0]  FX2_EP2_ADDR   = 2'b00;
   localparam logic [1:0]  FX2_EP4_ADDR   = 2'b01;
   localparam logic [1:0]  FX2_EP6_ADDR   = 2'b10;
   localparam logic [1:0]  FX2_EP8_ADDR   = 2'b11;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RD,
      ST_LATCH,
      ST_HI_SU,
      ST_HI_WR,
      ST_LO_SU,
      ST_LO_WR,
      ST_PEND
   } state_t;

   function automatic logic is_wr_state(input state_t s);
      return (s == ST_HI_WR) || (s == ST_LO_WR);
   endfunction

endpackage

// File: rtl/usb_fx2_slave_writer_if.sv
// Bus bundle between the writer, the USB word FIFO and the FX2 slave FIFO.
//   FifoRdData/FifoEmpty/FifoRdReq : USB FIFO read side (normal, non show-ahead)
//   FlagFull_n                     : FX2 FLAGB, endpoint full when low
//   FD/SLWR_n/PKTEND_n/FIFOADR     : FX2 slave-FIFO write side
//   SLOE_n/SLRD_n                  : FX2 read-side controls, parked inactive
// modport master : the writer; modport slave : the FIFO + FX2 environment.
interface usb_fx2_slave_writer_if;
   import usb_fx2_slave_writer_pkg::*;

   logic [WORD_W-1:0] FifoRdData;
   logic              FifoEmpty;
   logic              FifoRdReq;
   logic              FlagFull_n;
   logic [FD_W-1:0]   FD;
   logic              SLWR_n;
   logic              PKTEND_n;
   logic [1:0]        FIFOADR;
   logic              SLOE_n;
   logic              SLRD_n;

   modport master (
      input  FifoRdData, FifoEmpty, FlagFull_n,
      output FifoRdReq, FD, SLWR_n, PKTEND_n, FIFOADR, SLOE_n, SLRD_n
   );

   modport slave (
      output FifoRdData, FifoEmpty, FlagFull_n,
      input  FifoRdReq, FD, SLWR_n, PKTEND_n, FIFOADR, SLOE_n, SLRD_n
   );

endinterface

// File: rtl/usb_fx2_slave_writer.sv
// Drains 32-bit words from the USB FIFO and writes each as two 16-bit halves
// (high first) into the FX2 slave FIFO. A frame end marker that leaves a
// partly filled bulk packet is followed by a PKTEND_n pulse so the host gets
// the short packet immediately.
// Ports:
//   Clk     : FX2 IFCLK domain clock
//   Rst     : asynchronous active-low reset
//   Enable  : allow starting new word reads (a word in flight always completes)
//   Busy    : high whenever the FSM is not idle
//   bus     : FIFO + FX2 signals (usb_fx2_slave_writer_if.master)
module usb_fx2_slave_writer
   import usb_fx2_slave_writer_pkg::*;
#(
   parameter int          PKT_HALVES = 256,
   parameter logic [31:0] END_MARKER = FX2_END_MARKER,
   parameter logic [1:0]  EP_ADDR    = FX2_EP6_ADDR
) (
   input  logic                   Clk,
   input  logic                   Rst,
   input  logic                   Enable,
   output logic                   Busy,
   usb_fx2_slave_writer_if.master bus
);

   localparam int CNT_W = $clog2(PKT_HALVES);

   state_t            state, nxt;
   logic [WORD_W-1:0] hold;
   logic [FD_W-1:0]   fd_q;
   logic [CNT_W-1:0]  cnt;
   logic [CNT_W-1:0]  cnt_inc;
   logic              lo_settled;

   // Half counter mirrors the FX2 byte count; it wraps on the write that
   // fills a packet because the FX2 commits that packet by itself.
   assign cnt_inc = (cnt == CNT_W'(PKT_HALVES - 1)) ? '0 : cnt + CNT_W'(1);

   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) state <= ST_IDLE;
      else      state <= nxt;
   end

   // FD is registered and only changes one cycle after entering LO_SU, so the
   // high half stays on the bus for the cycle after its strobe (hold time)
   // and the low half is up a full cycle before its own strobe (setup).
   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         hold       <= '0;
         fd_q       <= '0;
         cnt        <= '0;
         lo_settled <= 1'b0;
      end else begin
         lo_settled <= (state == ST_LO_SU);
         case (state)
            ST_LATCH: begin
               hold <= bus.FifoRdData;
               fd_q <= bus.FifoRdData[WORD_W-1:FD_W];
            end
            ST_LO_SU: fd_q <= hold[FD_W-1:0];
            ST_HI_WR,
            ST_LO_WR: cnt  <= cnt_inc;
            ST_PEND:  cnt  <= '0;
            default: ;
         endcase
      end
   end

   always_comb begin
      nxt = state;
      case (state)
         ST_IDLE:  if (Enable && !bus.FifoEmpty) nxt = ST_RD;
         ST_RD:    nxt = ST_LATCH;
         ST_LATCH: nxt = ST_HI_SU;
         ST_HI_SU: if (bus.FlagFull_n) nxt = ST_HI_WR;
         ST_HI_WR: nxt = ST_LO_SU;
         // first LO_SU cycle is the high half's hold cycle; never strobe there
         ST_LO_SU: if (lo_settled && bus.FlagFull_n) nxt = ST_LO_WR;
         // an exactly filled packet was already committed by the FX2
         ST_LO_WR: nxt = (hold == END_MARKER && cnt_inc != '0) ? ST_PEND : ST_IDLE;
         ST_PEND:  nxt = ST_IDLE;
         default:  nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      bus.FifoRdReq = (state == ST_RD);
      bus.FD        = fd_q;
      bus.SLWR_n    = !is_wr_state(state);
      bus.PKTEND_n  = (state != ST_PEND);
      bus.FIFOADR   = EP_ADDR;
      bus.SLOE_n    = 1'b1;
      bus.SLRD_n    = 1'b1;
      Busy          = (state != ST_IDLE);
   end

endmodule

// File: tb/tb_usb_fx2_slave_writer.sv
module tb_usb_fx2_slave_writer;
   import usb_fx2_slave_writer_pkg::*;

   localparam int PKT = 256;

   typedef struct { logic [15:0] fd; logic pkt; } exp_t;
   typedef struct { logic [15:0] fd; logic [15:0] prev; int cyc; } slog_t;

   logic Clk = 1'b0;
   logic Rst;
   logic Enable;
   logic Busy;

   usb_fx2_slave_writer_if bus();

   usb_fx2_slave_writer #(.PKT_HALVES(PKT)) dut (
      .Clk(Clk), .Rst(Rst), .Enable(Enable), .Busy(Busy), .bus(bus)
   );

   always #5 Clk = ~Clk;

   // USB FIFO model: data appears the cycle after the read strobe
   logic [31:0] fifo_mem [0:4095];
   int          wr_ptr = 0;
   int          rd_ptr = 0;
   assign bus.FifoEmpty = (rd_ptr == wr_ptr);
   always @(posedge Clk) begin
      if (bus.FifoRdReq) begin
         bus.FifoRdData <= fifo_mem[rd_ptr];
         rd_ptr         <= rd_ptr + 1;
      end
   end

   // passive monitor: log strobes, setup/hold samples and packet ends
   slog_t       slog [$];
   logic [15:0] after_q [$];
   int          plog [$];
   int          cyc = 0;
   int          both = 0;
   logic [15:0] prev_fd = '0;
   logic        was_wr = 1'b0;
   logic        mon_en = 1'b1;
   always @(negedge Clk) begin
      cyc     <= cyc + 1;
      prev_fd <= bus.FD;
      was_wr  <= mon_en && !bus.SLWR_n;
      if (mon_en) begin
         if (!bus.SLWR_n) slog.push_back('{bus.FD, prev_fd, cyc});
         if (was_wr) after_q.push_back(bus.FD);
         if (!bus.PKTEND_n) plog.push_back(cyc);
         if (!bus.SLWR_n && !bus.PKTEND_n) both <= both + 1;
      end
   end

   initial begin
      #900000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // reference model: expected write sequence from the word stream
   int   tests = 0;
   int   fails = 0;
   exp_t exp_q [$];
   int   m_cnt = 0;
   int   sidx = 0;
   int   pidx = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic push(input logic [31:0] w);
      logic pkt;
      fifo_mem[wr_ptr] = w;
      wr_ptr++;
      exp_q.push_back('{w[31:16], 1'b0});
      m_cnt = (m_cnt + 2) % PKT;
      pkt = (w == FX2_END_MARKER) && (m_cnt != 0);
      exp_q.push_back('{w[15:0], pkt});
      if (pkt) m_cnt = 0;
   endtask

   function automatic logic [31:0] rand_word();
      logic [31:0] w;
      do w = $urandom; while (w == FX2_END_MARKER);
      return w;
   endfunction

   task automatic wait_idle(input int lim);
      bit ok = 0;
      for (int i = 0; i < lim; i++) begin
         @(negedge Clk);
         if (bus.FifoEmpty && !Busy) begin ok = 1; break; end
      end
      repeat (2) @(negedge Clk);
      tests++;
      assert (ok) else begin
         fails++;
         $error("FAIL idle_timeout: observed busy after %0d cycles, expected idle", lim);
      end
   endtask

   task automatic wait_strobe(input int lim);
      bit ok = 0;
      for (int i = 0; i < lim; i++) begin
         @(negedge Clk);
         if (!bus.SLWR_n) begin ok = 1; break; end
      end
      tests++;
      assert (ok) else begin
         fails++;
         $error("FAIL strobe_timeout: observed no SLWR_n in %0d cycles, expected one", lim);
      end
   endtask

   // compare logged bus activity against the model and consume both
   task automatic check_log();
      exp_t e;
      chk("n_strobes", slog.size() - sidx, exp_q.size());
      while (exp_q.size() > 0 && sidx < slog.size()) begin
         e = exp_q.pop_front();
         chk("fd_strobe", slog[sidx].fd, e.fd);
         chk("fd_setup", slog[sidx].prev, e.fd);
         if (sidx < after_q.size()) chk("fd_hold", after_q[sidx], e.fd);
         if (e.pkt) begin
            chk("pktend_seen", plog.size() > pidx, 1);
            if (plog.size() > pidx) begin
               chk("pktend_cyc", plog[pidx], slog[sidx].cyc + 1);
               pidx++;
            end
         end
         sidx++;
      end
      chk("extra_pktend", plog.size() - pidx, 0);
      chk("slwr_pktend_overlap", both, 0);
      exp_q.delete();
      sidx = slog.size();
      pidx = plog.size();
   endtask

   initial begin
      logic [31:0] w;
      int          pbase, sbase, k;
      bit          ok;

      // reset state
      Rst = 1'b0; Enable = 1'b0; bus.FlagFull_n = 1'b1; bus.FifoRdData = '0;
      repeat (3) @(negedge Clk);
      chk("rst_rdreq", bus.FifoRdReq, 0);
      chk("rst_fd", bus.FD, 0);
      chk("rst_slwr", bus.SLWR_n, 1);
      chk("rst_pktend", bus.PKTEND_n, 1);
      chk("rst_fifoadr", bus.FIFOADR, FX2_EP6_ADDR);
      chk("rst_sloe", bus.SLOE_n, 1);
      chk("rst_slrd", bus.SLRD_n, 1);
      chk("rst_busy", Busy, 0);
      chk("rst_cnt", dut.cnt, 0);
      Rst = 1'b1;
      @(negedge Clk);

      // single word, no stall
      sbase = slog.size(); pbase = plog.size();
      push(32'h12345678);
      Enable = 1'b1;
      wait_idle(50);
      chk("t1_strobes", slog.size() - sbase, 2);
      if (slog.size() - sbase >= 2)
         chk("t1_gap", slog[sbase + 1].cyc - slog[sbase].cyc, 3);
      chk("t1_pktend", plog.size() - pbase, 0);
      chk("t1_cnt", dut.cnt, 2);
      check_log();

      // three data words then the marker
      sbase = slog.size(); pbase = plog.size();
      for (int i = 0; i < 3; i++) push(rand_word());
      push(FX2_END_MARKER);
      wait_idle(100);
      chk("t2_strobes", slog.size() - sbase, 8);
      chk("t2_pktend", plog.size() - pbase, 1);
      chk("t2_cnt", dut.cnt, 0);
      check_log();

      // random stream with markers, random gaps and random full flag
      fork
         begin
            for (int i = 0; i < 24; i++) begin
               repeat ($urandom_range(0, 8)) @(negedge Clk);
               if ($urandom_range(0, 3) == 0) push(FX2_END_MARKER);
               else                           push(rand_word());
            end
         end
         begin
            repeat (300) begin
               @(negedge Clk);
               bus.FlagFull_n = ($urandom_range(0, 3) != 0);
            end
            bus.FlagFull_n = 1'b1;
         end
      join
      wait_idle(2000);
      chk("rand_cnt", dut.cnt, m_cnt);
      check_log();

      // marker lands on halves 255..256: packet auto-commits, no PKTEND
      pbase = plog.size();
      k = ((254 - m_cnt + PKT) % PKT) / 2;
      for (int i = 0; i < k; i++) push(rand_word());
      push(FX2_END_MARKER);
      wait_idle(4000);
      chk("wrap_pktend", plog.size() - pbase, 0);
      chk("wrap_cnt", dut.cnt, 0);
      check_log();

      // full stall while in LO_SU
      w = rand_word();
      push(w);
      wait_strobe(50);
      bus.FlagFull_n = 1'b0;
      @(negedge Clk);
      for (int i = 0; i < 20; i++) begin
         @(negedge Clk);
         chk("stall_slwr", bus.SLWR_n, 1);
         chk("stall_fd", bus.FD, w[15:0]);
      end
      bus.FlagFull_n = 1'b1;
      @(negedge Clk);
      chk("stall_release_strobe", bus.SLWR_n, 0);
      wait_idle(50);
      chk("stall_cnt", dut.cnt, m_cnt);
      check_log();

      // reset while in HI_WR
      mon_en = 1'b0;
      push(rand_word());
      wait_strobe(50);
      Rst = 1'b0;
      #1;
      chk("midrst_slwr", bus.SLWR_n, 1);
      chk("midrst_fd", bus.FD, 0);
      chk("midrst_busy", Busy, 0);
      chk("midrst_pktend", bus.PKTEND_n, 1);
      chk("midrst_cnt", dut.cnt, 0);
      exp_q.delete();
      m_cnt = 0;
      wr_ptr = rd_ptr;
      @(negedge Clk);
      Rst = 1'b1;
      repeat (2) @(negedge Clk);
      sidx = slog.size(); pidx = plog.size();
      mon_en = 1'b1;
      push(rand_word());
      wait_idle(50);
      chk("postrst_cnt", dut.cnt, 2);
      check_log();

      // Enable dropped during HI_SU with words still queued
      Enable = 1'b0;
      bus.FlagFull_n = 1'b0;
      push(rand_word());
      push(rand_word());
      @(negedge Clk);
      Enable = 1'b1;
      ok = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge Clk);
         if (Busy) begin ok = 1; break; end
      end
      chk("en_started", ok, 1);
      repeat (2) @(negedge Clk);
      Enable = 1'b0;
      repeat (5) @(negedge Clk);
      chk("en_stall_busy", Busy, 1);
      chk("en_stall_slwr", bus.SLWR_n, 1);
      bus.FlagFull_n = 1'b1;
      repeat (30) @(negedge Clk);
      chk("en_idle_busy", Busy, 0);
      chk("en_no_new_read", wr_ptr - rd_ptr, 1);
      Enable = 1'b1;
      wait_idle(100);
      chk("en_cnt", dut.cnt, m_cnt);
      check_log();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
